// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake and instruction-memory write port of the encoder/loader.
//   master : loader front end (drives the field bundle, observes the memory port)
//   slave  : instr_encoder_loader (accepts bundles, drives the memory write port)
// Signals:
//   in_valid/in_ready       bundle handshake
//   in_op/in_rs1/in_rs2/in_rd/in_imm/in_last  instruction fields
//   mem_we/mem_addr/mem_wdata                  instruction memory write port
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [2:0]               in_op;
  logic [4:0]               in_rs1;
  logic [4:0]               in_rs2;
  logic [4:0]               in_rd;
  logic signed [31:0]       in_imm;
  logic                     in_last;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [31:0]              mem_wdata;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_rd, in_imm, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_rd, in_imm, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Instruction encoder / loader.
// Packs {op, rs1, rs2, rd, imm14} into a 32-bit word and writes one word into
// instruction memory per accepted bundle, starting at START_ADDR.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   start         one-cycle pulse, begins or restarts a load session
//   bus (slave)   field-bundle handshake in, memory write port out
//   busy          session in progress (ACCEPT or WRITE)
//   done          session finished, held until start or rst
//   err_range     sticky: immediate op with in_imm outside [-8192, 8191]
//   err_overflow  sticky: DEPTH words written without in_last
//   word_count    words written in this session
module instr_encoder_loader #(
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 256,
  parameter int START_ADDR = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  instr_encoder_loader_if.slave   bus,
  output logic                    busy,
  output logic                    done,
  output logic                    err_range,
  output logic                    err_overflow,
  output logic [ADDR_W:0]         word_count
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] START_C = ADDR_W'(START_ADDR);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [31:0]         word_q, word_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                erng_q, erng_d;
  logic                eovf_q, eovf_d;
  logic                in_ready_c;
  logic                mem_we_c;

  function automatic logic is_imm_op(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // The immediate field holds a signed 14-bit value.
  function automatic logic imm_out_of_range(input logic signed [31:0] imm);
    return (imm < -32'sd8192) || (imm > 32'sd8191);
  endfunction

  function automatic logic [31:0] encode_word(input logic [2:0] op,
                                              input logic [4:0] rs1,
                                              input logic [4:0] rs2,
                                              input logic [4:0] rd,
                                              input logic signed [31:0] imm);
    logic [13:0] imm14;
    imm14 = is_imm_op(op) ? imm[13:0] : 14'd0;
    return {op, rs1, rs2, rd, imm14};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      erng_q  <= 1'b0;
      eovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      erng_q  <= erng_d;
      eovf_q  <= eovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    last_d     = last_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    erng_d     = erng_q;
    eovf_d     = eovf_q;
    in_ready_c = (state_q == ACCEPT);
    busy       = (state_q == ACCEPT) || (state_q == WRITE);
    done       = (state_q == DONE);
    // A restart in WRITE discards the captured word, so the strobe is gated.
    mem_we_c   = (state_q == WRITE) && !start;

    if (start) begin
      // start wins over any handshake or pending write in the same cycle
      state_d = ACCEPT;
      cnt_d   = '0;
      erng_d  = 1'b0;
      eovf_d  = 1'b0;
    end else begin
      unique case (state_q)
        ACCEPT: begin
          if (bus.in_valid) begin
            word_d  = encode_word(bus.in_op, bus.in_rs1, bus.in_rs2, bus.in_rd, bus.in_imm);
            last_d  = bus.in_last;
            // Address is fixed at capture; the count cannot change before WRITE.
            addr_d  = START_C + cnt_q[ADDR_W-1:0];
            if (is_imm_op(bus.in_op) && imm_out_of_range(bus.in_imm)) begin
              erng_d = 1'b1;
            end
            state_d = WRITE;
          end
        end
        WRITE: begin
          cnt_d = cnt_q + (ADDR_W+1)'(1);
          if (last_q) begin
            state_d = DONE;
          end else if (cnt_q + (ADDR_W+1)'(1) == DEPTH_C) begin
            state_d = DONE;
            eovf_d  = 1'b1;
          end else begin
            state_d = ACCEPT;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = word_q;
  assign err_range     = erng_q;
  assign err_overflow  = eovf_q;
  assign word_count    = cnt_q;

endmodule
